idex_stage: RTL

ID/EX pipeline stage for the segmented RISC-V core: registers the decoded instruction into the execute stage and owns load-use hazard detection and control-hazard flushing. It sits directly upstream of the forwarding unit and supplies `rs1_ex`, `rs2_ex` and the EX-stage control bits that the forwarding unit and EX-stage operand muxes consume. It also drives stall/flush controls back to the PC and IF/ID registers.

---
 rtl/idex_stage_pkg.sv | 28 ++
 rtl/idex_stage_if.sv | 67 ++++++
 rtl/idex_stage_hazard_detect.sv | 36 +++
 rtl/idex_stage.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/idex_stage_pkg.sv
// Shared types for the ID/EX pipeline stage.
//   XLEN         : datapath width
//   idex_ctrl_t  : EX-stage control bits carried through ID/EX
//   idex_state_t : load-use FSM states
//   BUBBLE       : control word of an inserted NOP (no write, no memory access)
package pipe_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic       RUWr;
        logic       DMRd;
        logic       DMWr;
        logic [3:0] ALUOp;
        logic       ALUASrc;
        logic       ALUBSrc;
        logic [4:0] BrOp;
        logic [1:0] RUDataWrSrc;
    } idex_ctrl_t;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } idex_state_t;

    localparam idex_ctrl_t BUBBLE = '0;

endpackage

// File: rtl/idex_stage_if.sv
// Decode-to-execute bundle of the ID/EX stage.
//   master : upstream/decode side, drives the *_de fields and NextPCSrc_ex,
//            observes the registered *_ex fields and the stall/flush controls
//   slave  : the idex_stage itself
interface idex_stage_if;
    import pipe_pkg::*;

    logic [4:0]      rs1_de;
    logic [4:0]      rs2_de;
    logic [4:0]      rd_de;
    logic            RUWr_de;
    logic            DMRd_de;
    logic            DMWr_de;
    logic [3:0]      ALUOp_de;
    logic            ALUASrc_de;
    logic            ALUBSrc_de;
    logic [4:0]      BrOp_de;
    logic [1:0]      RUDataWrSrc_de;
    logic [XLEN-1:0] pc_de;
    logic [XLEN-1:0] ru_rs1_de;
    logic [XLEN-1:0] ru_rs2_de;
    logic [XLEN-1:0] imm_de;
    logic            NextPCSrc_ex;

    logic [4:0]      rs1_ex;
    logic [4:0]      rs2_ex;
    logic [4:0]      rd_ex;
    logic            RUWr_ex;
    logic            DMRd_ex;
    logic            DMWr_ex;
    logic [3:0]      ALUOp_ex;
    logic            ALUASrc_ex;
    logic            ALUBSrc_ex;
    logic [4:0]      BrOp_ex;
    logic [1:0]      RUDataWrSrc_ex;
    logic [XLEN-1:0] pc_ex;
    logic [XLEN-1:0] ru_rs1_ex;
    logic [XLEN-1:0] ru_rs2_ex;
    logic [XLEN-1:0] imm_ex;

    logic            stall_pc;
    logic            stall_de;
    logic            flush_de;
    logic [31:0]     stall_cnt;
    logic [31:0]     flush_cnt;

    modport master (
        output rs1_de, rs2_de, rd_de, RUWr_de, DMRd_de, DMWr_de, ALUOp_de,
               ALUASrc_de, ALUBSrc_de, BrOp_de, RUDataWrSrc_de,
               pc_de, ru_rs1_de, ru_rs2_de, imm_de, NextPCSrc_ex,
        input  rs1_ex, rs2_ex, rd_ex, RUWr_ex, DMRd_ex, DMWr_ex, ALUOp_ex,
               ALUASrc_ex, ALUBSrc_ex, BrOp_ex, RUDataWrSrc_ex,
               pc_ex, ru_rs1_ex, ru_rs2_ex, imm_ex,
               stall_pc, stall_de, flush_de, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1_de, rs2_de, rd_de, RUWr_de, DMRd_de, DMWr_de, ALUOp_de,
               ALUASrc_de, ALUBSrc_de, BrOp_de, RUDataWrSrc_de,
               pc_de, ru_rs1_de, ru_rs2_de, imm_de, NextPCSrc_ex,
        output rs1_ex, rs2_ex, rd_ex, RUWr_ex, DMRd_ex, DMWr_ex, ALUOp_ex,
               ALUASrc_ex, ALUBSrc_ex, BrOp_ex, RUDataWrSrc_ex,
               pc_ex, ru_rs1_ex, ru_rs2_ex, imm_ex,
               stall_pc, stall_de, flush_de, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/idex_stage_hazard_detect.sv
// Combinational load-use / control-hazard priority logic for idex_stage.
//   rst_i          : synchronous reset, forces all controls low
//   state_i        : current idex_stage FSM state
//   DMRd_ex_i      : instruction in EX is a load
//   rd_ex_i        : destination of the instruction in EX
//   rs1_de_i/rs2_de_i : sources of the instruction in ID
//   NextPCSrc_ex_i : branch/jump taken in EX this cycle
//   stall_o        : hold PC and IF/ID
//   flush_o        : clear IF/ID
//   bubble_o       : load a bubble into ID/EX at the next edge
module hazard_detect
    import pipe_pkg::*;
(
    input  logic        rst_i,
    input  idex_state_t state_i,
    input  logic        DMRd_ex_i,
    input  logic [4:0]  rd_ex_i,
    input  logic [4:0]  rs1_de_i,
    input  logic [4:0]  rs2_de_i,
    input  logic        NextPCSrc_ex_i,
    output logic        stall_o,
    output logic        flush_o,
    output logic        bubble_o
);

    logic lu_haz;

    assign lu_haz = DMRd_ex_i & (rd_ex_i != 5'd0) &
                    ((rd_ex_i == rs1_de_i) | (rd_ex_i == rs2_de_i));

    // A taken branch squashes the consumer anyway, so flush wins over lu_haz.
    assign flush_o  = ~rst_i & NextPCSrc_ex_i;
    assign stall_o  = ~rst_i & ~NextPCSrc_ex_i & (state_i == RUN) & lu_haz;
    assign bubble_o = flush_o | stall_o;

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use stall and control-hazard flush.
//   clk  : core clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : idex_stage_if.slave, decode inputs (*_de, NextPCSrc_ex), registered
//          EX outputs (*_ex), stall_pc/stall_de/flush_de, stall_cnt/flush_cnt
// Build option: HAZ_PERF_CNT_EN enables the saturating stall/flush counters;
// without it both counter outputs are tied to zero.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | normal capture; a load-use hazard stalls one cycle
// LU_STALL | bubble sits in EX, held decode inputs are captured, no stall
module idex_stage
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    idex_stage_if.slave bus
);

    idex_state_t     state_q, state_d;
    idex_ctrl_t      ctrl_q, ctrl_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ru_rs1_q, ru_rs1_d;
    logic [XLEN-1:0] ru_rs2_q, ru_rs2_d;
    logic [XLEN-1:0] imm_q, imm_d;

    logic stall;
    logic flush;
    logic bubble;

    hazard_detect u_hazard_detect (
        .rst_i          (rst),
        .state_i        (state_q),
        .DMRd_ex_i      (ctrl_q.DMRd),
        .rd_ex_i        (rd_q),
        .rs1_de_i       (bus.rs1_de),
        .rs2_de_i       (bus.rs2_de),
        .NextPCSrc_ex_i (bus.NextPCSrc_ex),
        .stall_o        (stall),
        .flush_o        (flush),
        .bubble_o       (bubble)
    );

    always_comb begin
        ctrl_d.RUWr        = bus.RUWr_de & (bus.rd_de != 5'd0);  // never write x0
        ctrl_d.DMRd        = bus.DMRd_de;
        ctrl_d.DMWr        = bus.DMWr_de;
        ctrl_d.ALUOp       = bus.ALUOp_de;
        ctrl_d.ALUASrc     = bus.ALUASrc_de;
        ctrl_d.ALUBSrc     = bus.ALUBSrc_de;
        ctrl_d.BrOp        = bus.BrOp_de;
        ctrl_d.RUDataWrSrc = bus.RUDataWrSrc_de;
        rs1_d              = bus.rs1_de;
        rs2_d              = bus.rs2_de;
        rd_d               = bus.rd_de;
        pc_d               = bus.pc_de;
        ru_rs1_d           = bus.ru_rs1_de;
        ru_rs2_d           = bus.ru_rs2_de;
        imm_d              = bus.imm_de;
        if (bubble) begin
            ctrl_d   = BUBBLE;
            rs1_d    = '0;
            rs2_d    = '0;
            rd_d     = '0;
            pc_d     = '0;
            ru_rs1_d = '0;
            ru_rs2_d = '0;
            imm_d    = '0;
        end
        // stall already excludes flush and LU_STALL, so every other case is RUN
        state_d = stall ? LU_STALL : RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            ctrl_q   <= BUBBLE;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            pc_q     <= '0;
            ru_rs1_q <= '0;
            ru_rs2_q <= '0;
            imm_q    <= '0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            pc_q     <= pc_d;
            ru_rs1_q <= ru_rs1_d;
            ru_rs2_q <= ru_rs2_d;
            imm_q    <= imm_d;
        end
    end

    assign bus.rs1_ex         = rs1_q;
    assign bus.rs2_ex         = rs2_q;
    assign bus.rd_ex          = rd_q;
    assign bus.RUWr_ex        = ctrl_q.RUWr;
    assign bus.DMRd_ex        = ctrl_q.DMRd;
    assign bus.DMWr_ex        = ctrl_q.DMWr;
    assign bus.ALUOp_ex       = ctrl_q.ALUOp;
    assign bus.ALUASrc_ex     = ctrl_q.ALUASrc;
    assign bus.ALUBSrc_ex     = ctrl_q.ALUBSrc;
    assign bus.BrOp_ex        = ctrl_q.BrOp;
    assign bus.RUDataWrSrc_ex = ctrl_q.RUDataWrSrc;
    assign bus.pc_ex          = pc_q;
    assign bus.ru_rs1_ex      = ru_rs1_q;
    assign bus.ru_rs2_ex      = ru_rs2_q;
    assign bus.imm_ex         = imm_q;

    assign bus.stall_pc = stall;
    assign bus.stall_de = stall;
    assign bus.flush_de = flush;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturate instead of wrapping so a long run never reads as a small count.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif

endmodule
